// File: rtl/dac_pkg.sv
// Shared types and frame layout for the dual-channel DAC SPI transmitter.
// Frame bits: {ch, BUF, GA_n, SHDN_n, data[11:0]}, sent MSB first.
package dac_pkg;

    localparam int FRAME_W = 16;
    localparam int CH      = 15;
    localparam int BUF     = 14;
    localparam int GA_N    = 13;
    localparam int SHDN_N  = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT_A = 3'd1,
        GAP     = 3'd2,
        SHIFT_B = 3'd3,
        LDAC    = 3'd4
    } state_t;

    // Unbuffered reference, 1x gain, shutdown controlled by the channel enable.
    function automatic logic [FRAME_W-1:0] make_frame(input logic       ch,
                                                      input logic       en,
                                                      input logic [11:0] code);
        logic [FRAME_W-1:0] f;
        f         = {FRAME_W{1'b0}};
        f[CH]     = ch;
        f[BUF]    = 1'b0;
        f[GA_N]   = 1'b1;
        f[SHDN_N] = en;
        f[11:0]   = code;
        return f;
    endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample-side inputs and SPI/status outputs of the DAC transmitter.
// The slave modport is the transmitter's view; master is the driver's view.
interface dac_spi_tx_if;

    logic        clk_sampling;
    logic        enableA;
    logic        enableB;
    logic [11:0] dacA_word;
    logic [11:0] dacB_word;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic        ldac_n;
    logic        busy;
    logic        frame_done;
    logic [7:0]  overrun_cnt;

    modport master (
        output clk_sampling, enableA, enableB, dacA_word, dacB_word,
        input  sclk, mosi, cs_n, ldac_n, busy, frame_done, overrun_cnt
    );

    modport slave (
        input  clk_sampling, enableA, enableB, dacA_word, dacB_word,
        output sclk, mosi, cs_n, ldac_n, busy, frame_done, overrun_cnt
    );

endinterface

// File: rtl/dac_spi_frame.sv
// Shifts one 16-bit frame out as SPI mode 0: cs_n low for 32*CLK_DIV clks.
// done is high on the last clk of the frame; all pins come from flops.
module dac_spi_frame
    import dac_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               sclk,
    output logic               mosi,
    output logic               cs_n,
    output logic               done
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0]         div_cnt_r;
    logic [3:0]         bit_cnt_r;
    logic [FRAME_W-2:0] shift_r;
    logic               active_r;
    logic               sclk_r;
    logic               mosi_r;
    logic               cs_n_r;
    logic               half_end_s;

    assign half_end_s = active_r && (div_cnt_r == DIV_LAST);
    assign done       = half_end_s && sclk_r && (bit_cnt_r == 4'd15);

    // Half-period divider, bit counter and shifter; mosi moves only on sclk fall or load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= 8'd0;
            bit_cnt_r <= 4'd0;
            shift_r   <= {(FRAME_W-1){1'b0}};
            active_r  <= 1'b0;
            sclk_r    <= 1'b0;
            mosi_r    <= 1'b0;
            cs_n_r    <= 1'b1;
        end else if (start) begin
            div_cnt_r <= 8'd0;
            bit_cnt_r <= 4'd0;
            shift_r   <= frame[FRAME_W-2:0];
            active_r  <= 1'b1;
            sclk_r    <= 1'b0;
            mosi_r    <= frame[FRAME_W-1];
            cs_n_r    <= 1'b0;
        end else if (half_end_s) begin
            div_cnt_r <= 8'd0;
            if (!sclk_r) begin
                sclk_r <= 1'b1;
            end else if (bit_cnt_r == 4'd15) begin
                sclk_r   <= 1'b0;
                active_r <= 1'b0;
                cs_n_r   <= 1'b1;
            end else begin
                sclk_r    <= 1'b0;
                bit_cnt_r <= bit_cnt_r + 4'd1;
                mosi_r    <= shift_r[FRAME_W-2];
                shift_r   <= {shift_r[FRAME_W-3:0], 1'b0};
            end
        end else if (active_r) begin
            div_cnt_r <= div_cnt_r + 8'd1;
        end
    end

    assign sclk = sclk_r;
    assign mosi = mosi_r;
    assign cs_n = cs_n_r;

endmodule

// File: rtl/dac_spi_tx.sv
// Dual-channel DAC transmitter: frame A, cs_n gap, frame B, then an ldac_n pulse.
// One frame shifter is shared by both channels; B's frame is latched at the strobe.
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2,
    parameter int LDAC_W  = 2
) (
    input logic         clk,
    input logic         rst_n,
    dac_spi_tx_if.slave bus
);

    localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);
    localparam logic [7:0] LDAC_LAST = 8'(LDAC_W - 1);

    state_t             state_r, state_s;
    logic [7:0]         cnt_r, cnt_s;
    logic [7:0]         overrun_r, overrun_s;
    logic [FRAME_W-1:0] frame_b_r, frame_b_s;
    logic               ldac_n_r, ldac_n_s;
    logic               busy_r, busy_s;
    logic               frame_done_r, frame_done_s;
    logic               accept_s, start_s, done_s;
    logic [FRAME_W-1:0] frame_s;

    // The clk that raises frame_done is still treated as busy for new strobes.
    assign accept_s = bus.clk_sampling && (state_r == IDLE) && !frame_done_r;
    assign frame_s  = (state_r == IDLE) ? make_frame(1'b0, bus.enableA, bus.dacA_word)
                                        : frame_b_r;

    dac_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_s),
        .frame (frame_s),
        .sclk  (bus.sclk),
        .mosi  (bus.mosi),
        .cs_n  (bus.cs_n),
        .done  (done_s)
    );

    // State and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 8'd0;
            overrun_r    <= 8'd0;
            frame_b_r    <= {FRAME_W{1'b0}};
            ldac_n_r     <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            overrun_r    <= overrun_s;
            frame_b_r    <= frame_b_s;
            ldac_n_r     <= ldac_n_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
        end
    end

    // Next-state sequencing of the two frames, the gap and the latch pulse.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        frame_b_s    = frame_b_r;
        ldac_n_s     = ldac_n_r;
        busy_s       = busy_r;
        frame_done_s = 1'b0;
        start_s      = 1'b0;
        overrun_s    = overrun_r;

        if (bus.clk_sampling && !accept_s && (overrun_r != 8'hFF)) begin
            overrun_s = overrun_r + 8'd1;
        end else begin
            overrun_s = overrun_r;
        end

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    start_s   = 1'b1;
                    busy_s    = 1'b1;
                    frame_b_s = make_frame(1'b1, bus.enableB, bus.dacB_word);
                    state_s   = SHIFT_A;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT_A: begin
                if (done_s) begin
                    cnt_s   = 8'd0;
                    state_s = GAP;
                end else begin
                    state_s = SHIFT_A;
                end
            end
            GAP: begin
                if (cnt_r == GAP_LAST) begin
                    start_s = 1'b1;
                    state_s = SHIFT_B;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            SHIFT_B: begin
                if (done_s) begin
                    cnt_s    = 8'd0;
                    ldac_n_s = 1'b0;
                    state_s  = LDAC;
                end else begin
                    state_s = SHIFT_B;
                end
            end
            LDAC: begin
                if (cnt_r == LDAC_LAST) begin
                    ldac_n_s     = 1'b1;
                    busy_s       = 1'b0;
                    frame_done_s = 1'b1;
                    state_s      = IDLE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                ldac_n_s = 1'b1;
                busy_s   = 1'b0;
                state_s  = IDLE;
            end
        endcase
    end

    assign bus.ldac_n      = ldac_n_r;
    assign bus.busy        = busy_r;
    assign bus.frame_done  = frame_done_r;
    assign bus.overrun_cnt = overrun_r;

endmodule
